imager: RTL and testbench
=========================

IMAGER -- requirements
Module: imager

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 10, pixel width; NUM_ROWS_WIDTH, default 12, row-count width; NUM_COLS_WIDTH, default 12, column-count width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock.
- reset_n  in  1  reset; one clock, synchronous, active-low.
- enable  in  1  run pattern generator.
- mode  in  2  0=bayer flat, 1=column ramp, 2=noise, 3=row+col ramp.
- bayer_red, bayer_gr, bayer_blue, bayer_gb  in  DATA_WIDTH each  per-site values for mode 0.
- num_active_rows, num_virtual_rows  in  NUM_ROWS_WIDTH each  active/blanking rows.
- num_active_cols, num_virtual_cols  in  NUM_COLS_WIDTH each  active/blanking columns.
- sync_row_start, sync_rows  in  NUM_ROWS_WIDTH each  sync window start row and length.
- noise_seed  in  16  LFSR seed.
- dat  out  DATA_WIDTH  pixel.
- fv  out  1  frame valid.
- lv  out  1  line valid.
- sync  out  1  sync pulse.

Function
REQ-003 SHALL keep row counter r (NUM_ROWS_WIDTH+1 bits) and column counter c (NUM_COLS_WIDTH+1 bits); c counts 0..AC+VC-1, then wraps to 0 and r increments; r wraps to 0 after AR+VR-1.
REQ-004 SHALL treat num_virtual_cols=0 and num_virtual_rows=0 as 1.
REQ-005 SHALL latch all configuration inputs when r=0 and c=0; mid-frame changes take effect at the next frame.
REQ-006 SHALL drive fv=1 iff r<AR.
REQ-007 SHALL drive lv=1 iff r<AR and c<AC.
REQ-008 SHALL drive sync=1 iff sync_row_start<=r<sync_row_start+sync_rows; the sum SHALL be computed one bit wider; sync_rows=0 gives no sync.
REQ-009 SHALL register dat, fv, lv and sync, giving one cycle latency from counter state; all four are aligned.
REQ-010 SHALL drive dat=0 whenever lv=0.
REQ-011 Mode 0 SHALL output by site:
- even r, even c: bayer_red.
- even r, odd c: bayer_gr.
- odd r, even c: bayer_gb.
- odd r, odd c: bayer_blue.
REQ-012 Mode 1 SHALL output dat=c truncated to DATA_WIDTH.
REQ-013 Mode 3 SHALL output dat=(r+c) truncated to DATA_WIDTH.
REQ-014 Mode 2 SHALL use a 16-bit Galois LFSR, mask 16'hB400, and output dat=lfsr[DATA_WIDTH-1:0]:
- LFSR reloads noise_seed at every frame start (r=0, c=0).
- A seed of 0 is replaced by 1.
- LFSR advances once per cycle with lv=1.
REQ-015 With AR=0 or AC=0, fv and lv SHALL stay 0 (AR=0) or lv stays 0 (AC=0); counters still run.
REQ-016 enable=0 SHALL hold counters at 0 and force outputs to 0 on the next clock; on re-enable, the frame starts at r=0, c=0.
REQ-017 mode values are decoded from the latched configuration only.

Reset
REQ-018 reset_n=0 at a clk edge SHALL clear r, c, dat, fv, lv and sync to 0, load the LFSR with 1, and clear latched configuration to 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately; after release, generation restarts at r=0, c=0 if enable=1.

Structure
REQ-020 Mode encodings (MODE_BAYER=0, MODE_COL_RAMP=1, MODE_NOISE=2, MODE_DIAG=3) and the LFSR mask SHALL be constants in a shared package imager_pkg.
REQ-021 The LFSR SHALL be one sub-module, imager_lfsr (ports: clk, reset_n, load, seed, advance, q); all other logic stays in imager.

Verification
REQ-022 Timing: AR=4, VR=2, AC=8, VC=3, mode=1, enable=1 -> 66 clocks per frame; fv high 44 clocks; lv high 8 clocks per row; dat 0..7 in every active row.
REQ-023 Bayer: mode=0, red=1, gr=2, gb=3, blue=4, AC=4 -> row0 gives 1,2,1,2; row1 gives 3,4,3,4.
REQ-024 Sync: sync_row_start=5, sync_rows=1, AR=4, VR=2 -> sync high for exactly the 11 clocks of row 5 (AC+VC=11) each frame, with fv=0.
REQ-025 Noise: mode=2, seed=16'h0001 -> first pixel 1, second 16'hB400 truncated to 10 bits (0); two consecutive frames are identical; seed 0 gives the same frames as seed 1.
REQ-026 Reset/enable: pulse reset_n low mid-row, or drop enable -> all outputs 0 the next clock; on resumption the first lv run starts at c=0 with dat=0 (mode 1).
REQ-027 Config latch: change AC from 8 to 4 mid-frame -> the current frame keeps 8-wide lines; the next frame has 4-wide lines.

Source files
------------

// File: rtl/imager_pkg.sv
// Shared constants and helpers for the imager test-pattern generator.
// Holds the mode encodings and the noise LFSR polynomial.
package imager_pkg;

    typedef enum logic [1:0] {
        MODE_BAYER    = 2'd0,
        MODE_COL_RAMP = 2'd1,
        MODE_NOISE    = 2'd2,
        MODE_DIAG     = 2'd3
    } mode_e;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One right-shifting Galois step: the bit shifted out folds the mask back in.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // An all-zero state would lock the LFSR, so zero seeds become 1.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        seed_fix = (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/imager_lfsr.sv
// 16-bit Galois noise source. A load restarts the sequence from the seed and,
// when advance is also high, steps past it in the same clock.
module imager_lfsr
    import imager_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] q
);

    logic [15:0] state;
    logic [15:0] base;

    always_comb begin
        base = load ? seed_fix(seed) : state;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= 16'd1;
        end else if (advance) begin
            state <= lfsr_step(base);
        end else begin
            state <= base;
        end
    end

    assign q = state;

endmodule

// File: rtl/imager.sv
// Raster test-pattern generator: row/column counters, frame/line/sync timing
// and four pixel patterns, all outputs registered and mutually aligned.
module imager
    import imager_pkg::*;
#(
    parameter int DATA_WIDTH     = 10,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    input  logic [DATA_WIDTH-1:0]     bayer_red,
    input  logic [DATA_WIDTH-1:0]     bayer_gr,
    input  logic [DATA_WIDTH-1:0]     bayer_blue,
    input  logic [DATA_WIDTH-1:0]     bayer_gb,
    input  logic [NUM_ROWS_WIDTH-1:0] num_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0] num_virtual_rows,
    input  logic [NUM_COLS_WIDTH-1:0] num_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0] num_virtual_cols,
    input  logic [NUM_ROWS_WIDTH-1:0] sync_row_start,
    input  logic [NUM_ROWS_WIDTH-1:0] sync_rows,
    input  logic [15:0]               noise_seed,
    output logic [DATA_WIDTH-1:0]     dat,
    output logic                      fv,
    output logic                      lv,
    output logic                      sync
);

    localparam int RW = NUM_ROWS_WIDTH + 1;
    localparam int CW = NUM_COLS_WIDTH + 1;

    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          frame_start;

    logic [1:0]                mode_q, mode_cur;
    logic [DATA_WIDTH-1:0]     red_q, gr_q, blue_q, gb_q;
    logic [DATA_WIDTH-1:0]     red_cur, gr_cur, blue_cur, gb_cur;
    logic [NUM_ROWS_WIDTH-1:0] ar_q, vr_q, ss_q, sr_q;
    logic [NUM_ROWS_WIDTH-1:0] ar_cur, vr_cur, ss_cur, sr_cur, vr_eff;
    logic [NUM_COLS_WIDTH-1:0] ac_q, vc_q;
    logic [NUM_COLS_WIDTH-1:0] ac_cur, vc_cur, vc_eff;
    logic [15:0]               seed_q, seed_cur;

    logic [RW-1:0]         row_total, sync_end;
    logic [CW-1:0]         col_total;
    logic                  c_last, r_last;
    logic                  fv_nxt, lv_nxt, sync_nxt;
    logic [15:0]           lfsr_q, noise_val;
    logic [DATA_WIDTH-1:0] pixel, dat_nxt;

    assign frame_start = (r == '0) && (c == '0);

    // At the first pixel of a frame the live inputs are the ones being latched,
    // so they drive that pixel too; the rest of the frame uses the held copy.
    always_comb begin
        mode_cur = frame_start ? mode             : mode_q;
        red_cur  = frame_start ? bayer_red        : red_q;
        gr_cur   = frame_start ? bayer_gr         : gr_q;
        blue_cur = frame_start ? bayer_blue       : blue_q;
        gb_cur   = frame_start ? bayer_gb         : gb_q;
        ar_cur   = frame_start ? num_active_rows  : ar_q;
        vr_cur   = frame_start ? num_virtual_rows : vr_q;
        ac_cur   = frame_start ? num_active_cols  : ac_q;
        vc_cur   = frame_start ? num_virtual_cols : vc_q;
        ss_cur   = frame_start ? sync_row_start   : ss_q;
        sr_cur   = frame_start ? sync_rows        : sr_q;
        seed_cur = frame_start ? noise_seed       : seed_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q <= '0;
            red_q  <= '0;
            gr_q   <= '0;
            blue_q <= '0;
            gb_q   <= '0;
            ar_q   <= '0;
            vr_q   <= '0;
            ac_q   <= '0;
            vc_q   <= '0;
            ss_q   <= '0;
            sr_q   <= '0;
            seed_q <= '0;
        end else if (frame_start) begin
            mode_q <= mode;
            red_q  <= bayer_red;
            gr_q   <= bayer_gr;
            blue_q <= bayer_blue;
            gb_q   <= bayer_gb;
            ar_q   <= num_active_rows;
            vr_q   <= num_virtual_rows;
            ac_q   <= num_active_cols;
            vc_q   <= num_virtual_cols;
            ss_q   <= sync_row_start;
            sr_q   <= sync_rows;
            seed_q <= noise_seed;
        end
    end

    // Blanking of zero would make the counters never wrap cleanly; treat it as 1.
    always_comb begin
        vr_eff    = (vr_cur == '0) ? NUM_ROWS_WIDTH'(1) : vr_cur;
        vc_eff    = (vc_cur == '0) ? NUM_COLS_WIDTH'(1) : vc_cur;
        row_total = {1'b0, ar_cur} + {1'b0, vr_eff};
        col_total = {1'b0, ac_cur} + {1'b0, vc_eff};
        c_last    = (c == col_total - CW'(1));
        r_last    = (r == row_total - RW'(1));
        sync_end  = {1'b0, ss_cur} + {1'b0, sr_cur};
        fv_nxt    = (r < {1'b0, ar_cur});
        lv_nxt    = fv_nxt && (c < {1'b0, ac_cur});
        sync_nxt  = (r >= {1'b0, ss_cur}) && (r < sync_end);
        noise_val = frame_start ? seed_fix(seed_cur) : lfsr_q;
    end

    always_comb begin
        pixel = '0;
        case (mode_e'(mode_cur))
            MODE_BAYER: begin
                case ({r[0], c[0]})
                    2'b00:   pixel = red_cur;
                    2'b01:   pixel = gr_cur;
                    2'b10:   pixel = gb_cur;
                    default: pixel = blue_cur;
                endcase
            end
            MODE_COL_RAMP: pixel = DATA_WIDTH'(c);
            MODE_NOISE:    pixel = DATA_WIDTH'(noise_val);
            default:       pixel = DATA_WIDTH'(r) + DATA_WIDTH'(c);
        endcase
        dat_nxt = lv_nxt ? pixel : '0;
    end

    imager_lfsr u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (frame_start),
        .seed    (seed_cur),
        .advance (enable && lv_nxt),
        .q       (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            r    <= '0;
            c    <= '0;
            dat  <= '0;
            fv   <= 1'b0;
            lv   <= 1'b0;
            sync <= 1'b0;
        end else begin
            dat  <= dat_nxt;
            fv   <= fv_nxt;
            lv   <= lv_nxt;
            sync <= sync_nxt;
            if (c_last) begin
                c <= '0;
                r <= r_last ? '0 : r + RW'(1);
            end else begin
                c <= c + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_imager.sv
// Self-checking bench for imager: a frame-level reference model fills an
// expected queue that is compared cycle by cycle against the DUT outputs.
module tb_imager;

    localparam int DW = 10;
    localparam int RW = 12;
    localparam int CW = 12;
    localparam int EW = DW + 3;

    typedef struct {
        int mode, red, gr, blue, gb, ar, vr, ac, vc, ss, sr, seed;
    } cfg_t;

    logic          clk = 1'b0;
    logic          reset_n, enable;
    logic [1:0]    mode;
    logic [DW-1:0] bayer_red, bayer_gr, bayer_blue, bayer_gb;
    logic [RW-1:0] num_active_rows, num_virtual_rows, sync_row_start, sync_rows;
    logic [CW-1:0] num_active_cols, num_virtual_cols;
    logic [15:0]   noise_seed;
    logic [DW-1:0] dat;
    logic          fv, lv, sync;

    logic [EW-1:0] exp_q[$];
    int            obs_dat[$];
    int            saved_dat[$];
    int            checks = 0;
    int            failures = 0;
    int            cyc_cnt, fv_cnt, lv_cnt, sync_cnt, sync_fv_cnt;

    imager #(
        .DATA_WIDTH     (DW),
        .NUM_ROWS_WIDTH (RW),
        .NUM_COLS_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .enable           (enable),
        .mode             (mode),
        .bayer_red        (bayer_red),
        .bayer_gr         (bayer_gr),
        .bayer_blue       (bayer_blue),
        .bayer_gb         (bayer_gb),
        .num_active_rows  (num_active_rows),
        .num_virtual_rows (num_virtual_rows),
        .num_active_cols  (num_active_cols),
        .num_virtual_cols (num_virtual_cols),
        .sync_row_start   (sync_row_start),
        .sync_rows        (sync_rows),
        .noise_seed       (noise_seed),
        .dat              (dat),
        .fv               (fv),
        .lv               (lv),
        .sync             (sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic cfg_t mk(input int m, input int ar, input int vr, input int ac, input int vc);
        cfg_t k;
        k.mode = m;  k.ar = ar;  k.vr = vr;  k.ac = ac;  k.vc = vc;
        k.red = 0;   k.gr = 0;   k.blue = 0; k.gb = 0;
        k.ss = 0;    k.sr = 0;   k.seed = 1;
        return k;
    endfunction

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic apply_cfg(input cfg_t k);
        mode             = 2'(k.mode);
        bayer_red        = DW'(k.red);
        bayer_gr         = DW'(k.gr);
        bayer_blue       = DW'(k.blue);
        bayer_gb         = DW'(k.gb);
        num_active_rows  = RW'(k.ar);
        num_virtual_rows = RW'(k.vr);
        num_active_cols  = CW'(k.ac);
        num_virtual_cols = CW'(k.vc);
        sync_row_start   = RW'(k.ss);
        sync_rows        = RW'(k.sr);
        noise_seed       = 16'(k.seed);
    endtask

    // Whole-frame reference: walks the raster and applies the pattern rules directly.
    task automatic model_frame(input cfg_t k);
        int          vr, vc, d;
        logic        s_, f_, l_;
        logic [15:0] lf;
        vr = (k.vr == 0) ? 1 : k.vr;
        vc = (k.vc == 0) ? 1 : k.vc;
        lf = (k.seed == 0) ? 16'd1 : 16'(k.seed);
        for (int row = 0; row < k.ar + vr; row++) begin
            for (int col = 0; col < k.ac + vc; col++) begin
                f_ = (row < k.ar);
                l_ = f_ && (col < k.ac);
                s_ = (row >= k.ss) && (row < k.ss + k.sr);
                d  = 0;
                if (l_) begin
                    case (k.mode)
                        0: d = (row % 2 == 0) ? ((col % 2 == 0) ? k.red : k.gr)
                                              : ((col % 2 == 0) ? k.gb  : k.blue);
                        1: d = col % (1 << DW);
                        2: begin
                            d  = int'(lf) % (1 << DW);
                            lf = galois(lf);
                        end
                        default: d = (row + col) % (1 << DW);
                    endcase
                end
                exp_q.push_back({s_, f_, l_, DW'(d)});
            end
        end
    endtask

    task automatic clear_stats();
        cyc_cnt = 0; fv_cnt = 0; lv_cnt = 0; sync_cnt = 0; sync_fv_cnt = 0;
        obs_dat.delete();
    endtask

    task automatic run_n(input string tag, input int n);
        logic [EW-1:0] e;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            check(tag, 32'({sync, fv, lv, dat}), 32'(e));
            cyc_cnt++;
            if (fv) fv_cnt++;
            if (lv) begin
                lv_cnt++;
                obs_dat.push_back(int'(dat));
            end
            if (sync) sync_cnt++;
            if (sync && fv) sync_fv_cnt++;
        end
    endtask

    task automatic run_all(input string tag);
        run_n(tag, exp_q.size());
    endtask

    // Drop enable for one clock (outputs must clear), then restart with a new setup.
    task automatic restart_with(input cfg_t k);
        @(negedge clk);
        enable = 1'b0;
        apply_cfg(k);
        @(posedge clk);
        #1;
        check("disable_zero", 32'({sync, fv, lv, dat}), 32'd0);
        @(negedge clk);
        enable = 1'b1;
        clear_stats();
    endtask

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL timeout: got no_finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        cfg_t k, kb;
        int   bayer_exp[8];

        // Reset with enable held high: everything must stay at zero.
        k = mk(1, 4, 2, 8, 3);
        reset_n = 1'b0;
        enable  = 1'b1;
        apply_cfg(k);
        repeat (3) @(posedge clk);
        #1;
        check("reset_zero", 32'({sync, fv, lv, dat}), 32'd0);

        // Frame timing with the column ramp.
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        model_frame(k);
        model_frame(k);
        run_all("timing");
        check("frame_cycles", cyc_cnt, 132);
        check("fv_cycles", fv_cnt, 88);
        check("lv_cycles", lv_cnt, 64);
        for (int i = 0; i < obs_dat.size(); i++) check("ramp_dat", obs_dat[i], i % 8);

        // Bayer sites.
        k = mk(0, 4, 2, 4, 3);
        k.red = 1; k.gr = 2; k.gb = 3; k.blue = 4;
        bayer_exp = '{1, 2, 1, 2, 3, 4, 3, 4};
        restart_with(k);
        model_frame(k);
        run_all("bayer");
        check("bayer_count", obs_dat.size(), 16);
        for (int i = 0; i < 8 && i < obs_dat.size(); i++) check("bayer_site", obs_dat[i], bayer_exp[i]);

        // Sync window in the blanking row.
        k = mk(1, 4, 2, 8, 3);
        k.ss = 5; k.sr = 1;
        restart_with(k);
        model_frame(k);
        model_frame(k);
        run_all("sync");
        check("sync_cycles", sync_cnt, 22);
        check("sync_with_fv", sync_fv_cnt, 0);

        // Noise: seed 1, then seed 0 must reproduce the same frames.
        k = mk(2, 4, 2, 8, 3);
        k.seed = 1;
        restart_with(k);
        model_frame(k);
        model_frame(k);
        run_all("noise1");
        check("noise_count", obs_dat.size(), 64);
        if (obs_dat.size() >= 2) begin
            check("noise_first", obs_dat[0], 1);
            check("noise_second", obs_dat[1], 0);
        end
        for (int i = 0; i < 32 && i + 32 < obs_dat.size(); i++)
            check("noise_repeat", obs_dat[i + 32], obs_dat[i] & 32'h3ff);
        saved_dat = obs_dat;
        k.seed = 0;
        restart_with(k);
        model_frame(k);
        model_frame(k);
        run_all("noise0");
        check("noise0_count", obs_dat.size(), saved_dat.size());
        for (int i = 0; i < obs_dat.size() && i < saved_dat.size(); i++)
            check("seed0_vs_seed1", obs_dat[i], saved_dat[i] & 32'h3ff);

        // Reset pulse mid-row, then resume.
        k = mk(1, 4, 2, 8, 3);
        restart_with(k);
        model_frame(k);
        run_n("pre_reset", 15);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mid_zero", 32'({sync, fv, lv, dat}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        clear_stats();
        model_frame(k);
        run_all("after_reset");
        if (obs_dat.size() > 0) check("reset_resume_dat", obs_dat[0], 0);

        // Enable drop mid-row, then resume.
        model_frame(k);
        run_n("pre_disable", 17);
        exp_q.delete();
        restart_with(k);
        model_frame(k);
        run_all("after_disable");
        if (obs_dat.size() > 0) check("enable_resume_dat", obs_dat[0], 0);

        // Mid-frame width change lands on the next frame only.
        k  = mk(1, 4, 2, 8, 3);
        kb = k;
        kb.ac = 4;
        restart_with(k);
        model_frame(k);
        model_frame(kb);
        run_n("latch", 1);
        @(negedge clk);
        apply_cfg(kb);
        run_all("latch");
        check("latch_lv_cycles", lv_cnt, 48);

        // Degenerate geometries.
        k = mk(1, 0, 2, 8, 3);
        restart_with(k);
        model_frame(k);
        run_all("ar_zero");
        check("ar_zero_fv", fv_cnt, 0);
        k = mk(3, 4, 2, 0, 3);
        restart_with(k);
        model_frame(k);
        run_all("ac_zero");
        check("ac_zero_lv", lv_cnt, 0);
        k = mk(3, 2, 0, 3, 0);
        restart_with(k);
        model_frame(k);
        run_all("blank_zero");
        check("blank_zero_cycles", cyc_cnt, 12);

        // Randomised setups, each with a mid-frame change into the next frame.
        for (int it = 0; it < 24; it++) begin
            k.mode = $urandom_range(0, 3);
            k.red  = $urandom_range(0, 1023);
            k.gr   = $urandom_range(0, 1023);
            k.blue = $urandom_range(0, 1023);
            k.gb   = $urandom_range(0, 1023);
            k.ar   = $urandom_range(0, 5);
            k.vr   = $urandom_range(0, 3);
            k.ac   = $urandom_range(0, 9);
            k.vc   = $urandom_range(0, 3);
            k.ss   = $urandom_range(0, 7);
            k.sr   = $urandom_range(0, 3);
            k.seed = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535);
            kb      = k;
            kb.mode = $urandom_range(0, 3);
            kb.ac   = $urandom_range(0, 9);
            kb.ar   = $urandom_range(0, 5);
            kb.sr   = $urandom_range(0, 3);
            kb.seed = $urandom_range(0, 65535);
            restart_with(k);
            model_frame(k);
            model_frame(kb);
            run_n("random", 1);
            @(negedge clk);
            apply_cfg(kb);
            run_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
